reorder_buffer: RTL and testbench

In-order completion tracker sitting directly downstream of `ex_stage`. It allocates one entry per dispatched micro-op and hands the entry index to the issue path, where it travels as `rob_idx`. It marks entries done from the eight `ex_stage` writeback lanes and retires up to `COMMIT_W` entries per cycle in program order. A committed mispredicted branch triggers a whole-machine redirect and empties the buffer.

---
 rtl/reorder_buffer.sv | 171 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order completion tracker: multi-lane allocate, writeback marking, in-order commit
// Commit group and readiness are derived from registered state only; flush_i overrides every other event.
module reorder_buffer #(
   parameter int DEPTH    = 64,
   parameter int DISP_W   = 4,
   parameter int COMMIT_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush_i,
   input  logic [DISP_W-1:0]   alloc_valid_i,
   input  logic [6:0]          alloc_dest_phys_i  [DISP_W],
   input  logic [6:0]          alloc_old_phys_i   [DISP_W],
   input  logic [4:0]          alloc_arch_i       [DISP_W],
   input  logic [DISP_W-1:0]   alloc_has_dest_i,
   output logic                alloc_ready_o,
   output logic [7:0]          alloc_rob_idx_o    [DISP_W],
   input  logic [7:0]          wb_valid_i,
   input  logic [7:0]          wb_rob_idx_i       [8],
   input  logic [7:0]          br_mispredict_i,
   input  logic [63:0]         br_target_i        [8],
   output logic [COMMIT_W-1:0] commit_valid_o,
   output logic [7:0]          commit_rob_idx_o   [COMMIT_W],
   output logic [4:0]          commit_arch_o      [COMMIT_W],
   output logic [6:0]          commit_dest_phys_o [COMMIT_W],
   output logic [6:0]          commit_old_phys_o  [COMMIT_W],
   output logic [COMMIT_W-1:0] commit_has_dest_o,
   output logic                redirect_valid_o,
   output logic [63:0]         redirect_pc_o,
   output logic [8:0]          count_o
);
   localparam int IW = $clog2(DEPTH);

   logic [IW-1:0]    head, tail;
   logic [8:0]       count;
   logic [DEPTH-1:0] valid, done, misp, has_dest;
   logic [63:0]      tgt       [DEPTH];
   logic [6:0]       dest_phys [DEPTH];
   logic [6:0]       old_phys  [DEPTH];
   logic [4:0]       arch      [DEPTH];

   logic [IW-1:0]       alloc_idx [DISP_W];
   logic [8:0]          n_alloc;
   logic [8:0]          n_alloc_eff;
   logic                misp_at_head;
   logic [IW-1:0]       cidx [COMMIT_W];
   logic [COMMIT_W-1:0] cmt;
   logic [8:0]          n_commit;
   logic                grp_go, grp_misp;
   logic [63:0]         grp_tgt;

   // Sparse lanes pack densely from tail; invalid lanes still report their would-be slot.
   always_comb begin
      n_alloc = '0;
      for (int k = 0; k < DISP_W; k++) begin
         alloc_idx[k]       = tail + IW'(n_alloc);
         alloc_rob_idx_o[k] = 8'(alloc_idx[k]);
         if (alloc_valid_i[k]) n_alloc = n_alloc + 9'd1;
      end
   end

   assign misp_at_head  = valid[head] && done[head] && misp[head];
   assign alloc_ready_o = (count <= 9'(DEPTH - DISP_W)) && !misp_at_head && !flush_i;
   assign n_alloc_eff   = alloc_ready_o ? n_alloc : 9'd0;
   assign count_o       = count;

   // A mispredicted entry retires but stops the group behind it.
   always_comb begin
      grp_go   = 1'b1;
      grp_misp = 1'b0;
      grp_tgt  = '0;
      n_commit = '0;
      cmt      = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         cidx[k] = head + IW'(k);
         cmt[k]  = grp_go && valid[cidx[k]] && done[cidx[k]];
         if (cmt[k]) begin
            n_commit = n_commit + 9'd1;
            if (misp[cidx[k]]) begin
               grp_misp = 1'b1;
               grp_tgt  = tgt[cidx[k]];
               grp_go   = 1'b0;
            end
         end else begin
            grp_go = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         valid            <= '0;
         done             <= '0;
         misp             <= '0;
         has_dest         <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tgt[i]       <= '0;
            dest_phys[i] <= '0;
            old_phys[i]  <= '0;
            arch[i]      <= '0;
         end
         commit_valid_o    <= '0;
         commit_has_dest_o <= '0;
         for (int k = 0; k < COMMIT_W; k++) begin
            commit_rob_idx_o[k]   <= '0;
            commit_arch_o[k]      <= '0;
            commit_dest_phys_o[k] <= '0;
            commit_old_phys_o[k]  <= '0;
         end
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
      end else if (flush_i) begin
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         valid            <= '0;
         commit_valid_o   <= '0;
         redirect_valid_o <= 1'b0;
      end else begin
         commit_valid_o   <= cmt;
         redirect_valid_o <= grp_misp;
         if (grp_misp) redirect_pc_o <= grp_tgt;
         for (int k = 0; k < COMMIT_W; k++) begin
            if (cmt[k]) begin
               commit_rob_idx_o[k]   <= 8'(cidx[k]);
               commit_arch_o[k]      <= arch[cidx[k]];
               commit_dest_phys_o[k] <= dest_phys[cidx[k]];
               commit_old_phys_o[k]  <= old_phys[cidx[k]];
               commit_has_dest_o[k]  <= has_dest[cidx[k]];
            end
         end
         if (grp_misp) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
         end else begin
            for (int l = 0; l < 8; l++) begin
               if (wb_valid_i[l] && ({1'b0, wb_rob_idx_i[l]} < 9'(DEPTH))
                   && valid[wb_rob_idx_i[l][IW-1:0]]) begin
                  done[wb_rob_idx_i[l][IW-1:0]] <= 1'b1;
                  misp[wb_rob_idx_i[l][IW-1:0]] <= br_mispredict_i[l];
                  tgt[wb_rob_idx_i[l][IW-1:0]]  <= br_target_i[l];
               end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
               if (cmt[k]) valid[cidx[k]] <= 1'b0;
            end
            if (alloc_ready_o) begin
               for (int k = 0; k < DISP_W; k++) begin
                  if (alloc_valid_i[k]) begin
                     valid[alloc_idx[k]]     <= 1'b1;
                     done[alloc_idx[k]]      <= 1'b0;
                     misp[alloc_idx[k]]      <= 1'b0;
                     dest_phys[alloc_idx[k]] <= alloc_dest_phys_i[k];
                     old_phys[alloc_idx[k]]  <= alloc_old_phys_i[k];
                     arch[alloc_idx[k]]      <= alloc_arch_i[k];
                     has_dest[alloc_idx[k]]  <= alloc_has_dest_i[k];
                  end
               end
            end
            head  <= head + IW'(n_commit);
            tail  <= tail + IW'(n_alloc_eff);
            count <= count + n_alloc_eff - n_commit;
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scenario and randomized checks of reorder_buffer against a program-order queue model
module tb_reorder_buffer;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_i;
   logic [3:0]  alloc_valid_i;
   logic [6:0]  alloc_dest_phys_i [4];
   logic [6:0]  alloc_old_phys_i  [4];
   logic [4:0]  alloc_arch_i      [4];
   logic [3:0]  alloc_has_dest_i;
   logic        alloc_ready_o;
   logic [7:0]  alloc_rob_idx_o   [4];
   logic [7:0]  wb_valid_i;
   logic [7:0]  wb_rob_idx_i      [8];
   logic [7:0]  br_mispredict_i;
   logic [63:0] br_target_i       [8];
   logic [3:0]  commit_valid_o;
   logic [7:0]  commit_rob_idx_o  [4];
   logic [4:0]  commit_arch_o     [4];
   logic [6:0]  commit_dest_phys_o[4];
   logic [6:0]  commit_old_phys_o [4];
   logic [3:0]  commit_has_dest_o;
   logic        redirect_valid_o;
   logic [63:0] redirect_pc_o;
   logic [8:0]  count_o;

   reorder_buffer dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .alloc_valid_i(alloc_valid_i), .alloc_dest_phys_i(alloc_dest_phys_i),
      .alloc_old_phys_i(alloc_old_phys_i), .alloc_arch_i(alloc_arch_i),
      .alloc_has_dest_i(alloc_has_dest_i), .alloc_ready_o(alloc_ready_o),
      .alloc_rob_idx_o(alloc_rob_idx_o), .wb_valid_i(wb_valid_i),
      .wb_rob_idx_i(wb_rob_idx_i), .br_mispredict_i(br_mispredict_i),
      .br_target_i(br_target_i), .commit_valid_o(commit_valid_o),
      .commit_rob_idx_o(commit_rob_idx_o), .commit_arch_o(commit_arch_o),
      .commit_dest_phys_o(commit_dest_phys_o), .commit_old_phys_o(commit_old_phys_o),
      .commit_has_dest_o(commit_has_dest_o), .redirect_valid_o(redirect_valid_o),
      .redirect_pc_o(redirect_pc_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      bit          done;
      bit          misp;
      logic [63:0] tgt;
      logic [6:0]  dest;
      logic [6:0]  old;
      logic [4:0]  arch;
      logic        hd;
   } ent_t;

   ent_t        q[$];
   int          m_tail;
   ent_t        e_lane[4];
   logic [3:0]  e_cv;
   logic        e_rv;
   logic [63:0] e_rpc;
   int          nvec = 0;
   int          nerr = 0;

   function automatic bit m_ready();
      return (q.size() <= DEPTH - 4) && !(q.size() > 0 && q[0].done && q[0].misp) && !flush_i;
   endfunction

   function automatic logic [32:0] exp_alloc();
      logic [32:0] r;
      int off;
      off = 0;
      r[32] = m_ready();
      for (int k = 0; k < 4; k++) begin
         r[8*k +: 8] = 8'((m_tail + off) % DEPTH);
         if (alloc_valid_i[k]) off++;
      end
      return r;
   endfunction

   function automatic logic [32:0] dut_alloc();
      return {alloc_ready_o, alloc_rob_idx_o[3], alloc_rob_idx_o[2], alloc_rob_idx_o[1], alloc_rob_idx_o[0]};
   endfunction

   function automatic logic [189:0] exp_reg();
      logic [115:0] s;
      s = '0;
      s[3:0] = e_cv;
      for (int k = 0; k < 4; k++)
         if (e_cv[k])
            s[4+28*k +: 28] = {8'(e_lane[k].idx), e_lane[k].arch, e_lane[k].dest, e_lane[k].old, e_lane[k].hd};
      return {9'(q.size()), e_rv, e_rv ? e_rpc : 64'h0, s};
   endfunction

   function automatic logic [189:0] dut_reg();
      logic [115:0] s;
      s = '0;
      s[3:0] = commit_valid_o;
      for (int k = 0; k < 4; k++)
         if (commit_valid_o[k])
            s[4+28*k +: 28] = {commit_rob_idx_o[k], commit_arch_o[k], commit_dest_phys_o[k],
                               commit_old_phys_o[k], commit_has_dest_o[k]};
      return {count_o, redirect_valid_o, redirect_valid_o ? redirect_pc_o : 64'h0, s};
   endfunction

   task automatic clr_inputs();
      flush_i = 1'b0;
      alloc_valid_i = '0;
      alloc_has_dest_i = '0;
      wb_valid_i = '0;
      br_mispredict_i = '0;
      for (int k = 0; k < 4; k++) begin
         alloc_dest_phys_i[k] = '0;
         alloc_old_phys_i[k] = '0;
         alloc_arch_i[k] = '0;
      end
      for (int l = 0; l < 8; l++) begin
         wb_rob_idx_i[l] = '0;
         br_target_i[l] = '0;
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_tail = 0;
      e_cv = '0;
      e_rv = 1'b0;
      e_rpc = '0;
   endtask

   task automatic set_alloc(input logic [3:0] mask);
      alloc_valid_i = mask;
      for (int k = 0; k < 4; k++) begin
         alloc_dest_phys_i[k] = 7'($urandom);
         alloc_old_phys_i[k] = 7'($urandom);
         alloc_arch_i[k] = 5'($urandom);
         alloc_has_dest_i[k] = 1'($urandom);
      end
   endtask

   task automatic set_wb(input int l, input int idx, input bit mp, input logic [63:0] t);
      wb_valid_i[l] = 1'b1;
      wb_rob_idx_i[l] = 8'(idx);
      br_mispredict_i[l] = mp;
      br_target_i[l] = t;
   endtask

   task automatic complete_pending();
      int l;
      l = 0;
      foreach (q[j])
         if (!q[j].done && l < 8) begin
            set_wb(l, q[j].idx, 1'b0, {$urandom, $urandom});
            l++;
         end
   endtask

   // Advance the model by one clock using the current inputs, then clock the DUT.
   task automatic tick();
      int n;
      bit mp, rdy;
      logic [63:0] pc;
      ent_t e;
      rdy = m_ready();
      pc = '0;
      if (flush_i) begin
         q.delete();
         m_tail = 0;
         e_cv = '0;
         e_rv = 1'b0;
      end else begin
         n = 0;
         mp = 1'b0;
         while (n < 4 && n < q.size() && !mp && q[n].done) begin
            mp = q[n].misp;
            pc = q[n].tgt;
            e_lane[n] = q[n];
            n++;
         end
         e_cv = 4'((1 << n) - 1);
         e_rv = mp;
         if (mp) e_rpc = pc;
         if (mp) begin
            q.delete();
            m_tail = 0;
         end else begin
            for (int l = 0; l < 8; l++)
               if (wb_valid_i[l])
                  foreach (q[j])
                     if (q[j].idx == int'(wb_rob_idx_i[l])) begin
                        q[j].done = 1'b1;
                        q[j].misp = br_mispredict_i[l];
                        q[j].tgt = br_target_i[l];
                     end
            repeat (n) void'(q.pop_front());
            if (rdy)
               for (int k = 0; k < 4; k++)
                  if (alloc_valid_i[k]) begin
                     e.idx = m_tail;
                     e.done = 1'b0;
                     e.misp = 1'b0;
                     e.tgt = '0;
                     e.dest = alloc_dest_phys_i[k];
                     e.old = alloc_old_phys_i[k];
                     e.arch = alloc_arch_i[k];
                     e.hd = alloc_has_dest_i[k];
                     q.push_back(e);
                     m_tail = (m_tail + 1) % DEPTH;
                  end
         end
      end
      @(posedge clk);
      #1;
      clr_inputs();
   endtask

   task automatic apply_reset();
      clr_inputs();
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      set_alloc(4'hF);
      #1;
      nvec++; if (alloc_ready_o !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b exp 1", alloc_ready_o); end
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (alloc_rob_idx_o[k] !== 8'(k)) begin nerr++; $display("FAIL reset_idx%0d got %0d exp %0d", k, alloc_rob_idx_o[k], k); end
      end
      nvec++; if (count_o !== 9'd0) begin nerr++; $display("FAIL reset_count got %0d exp 0", count_o); end
      nvec++; if ({commit_valid_o, redirect_valid_o} !== 5'b0) begin nerr++; $display("FAIL reset_valids got %b exp 0", {commit_valid_o, redirect_valid_o}); end
      clr_inputs();
   endtask

   task automatic test_out_of_order();
      int order[3] = '{2, 3, 1};
      set_alloc(4'hF);
      #1;
      nvec++; if (dut_alloc() !== exp_alloc()) begin nerr++; $display("FAIL ooo_alloc got %h exp %h", dut_alloc(), exp_alloc()); end
      tick();
      for (int i = 0; i < 3; i++) begin
         set_wb(0, order[i], 1'b0, 64'h0);
         tick();
         nvec++; if (commit_valid_o !== 4'b0) begin nerr++; $display("FAIL ooo_nocommit got %b exp 0", commit_valid_o); end
      end
      set_wb(0, 0, 1'b0, 64'h0);
      tick();
      nvec++; if (dut_reg() !== exp_reg()) begin nerr++; $display("FAIL ooo_wb0 got %h exp %h", dut_reg(), exp_reg()); end
      tick();
      nvec++; if (dut_reg() !== exp_reg()) begin nerr++; $display("FAIL ooo_commit got %h exp %h", dut_reg(), exp_reg()); end
      nvec++;
      if ({commit_valid_o, commit_rob_idx_o[0], commit_rob_idx_o[1], commit_rob_idx_o[2], commit_rob_idx_o[3], count_o}
          !== {4'hF, 8'd0, 8'd1, 8'd2, 8'd3, 9'd0}) begin
         nerr++; $display("FAIL ooo_group got cv=%b idx=%0d,%0d,%0d,%0d count=%0d exp cv=1111 idx=0,1,2,3 count=0",
                          commit_valid_o, commit_rob_idx_o[0], commit_rob_idx_o[1], commit_rob_idx_o[2], commit_rob_idx_o[3], count_o);
      end
   endtask

   task automatic test_full();
      for (int g = 0; g < 16; g++) begin
         set_alloc(4'hF);
         #1;
         nvec++; if (alloc_ready_o !== 1'b1) begin nerr++; $display("FAIL full_ready_g%0d got %b exp 1", g, alloc_ready_o); end
         tick();
      end
      set_alloc(4'hF);
      #1;
      nvec++; if ({alloc_ready_o, count_o} !== {1'b0, 9'd64}) begin nerr++; $display("FAIL full_at64 got ready=%b count=%0d exp ready=0 count=64", alloc_ready_o, count_o); end
      tick();
      nvec++; if (count_o !== 9'd64) begin nerr++; $display("FAIL full_ignored got %0d exp 64", count_o); end
      for (int l = 0; l < 4; l++) set_wb(l, q[l].idx, 1'b0, 64'h0);
      tick();
      set_alloc(4'hF);
      #1;
      nvec++; if (alloc_ready_o !== 1'b0) begin nerr++; $display("FAIL full_commit_cycle_ready got %b exp 0", alloc_ready_o); end
      tick();
      nvec++; if (dut_reg() !== exp_reg()) begin nerr++; $display("FAIL full_commit got %h exp %h", dut_reg(), exp_reg()); end
      nvec++; if ({alloc_ready_o, count_o} !== {1'b1, 9'd60}) begin nerr++; $display("FAIL full_reopen got ready=%b count=%0d exp ready=1 count=60", alloc_ready_o, count_o); end
      for (int c = 0; c < 80 && q.size() > 0; c++) begin
         complete_pending();
         tick();
         nvec++; if (dut_reg() !== exp_reg()) begin nerr++; $display("FAIL full_drain got %h exp %h", dut_reg(), exp_reg()); end
      end
      nvec++; if (count_o !== 9'd0) begin nerr++; $display("FAIL full_drained got %0d exp 0", count_o); end
   endtask

   task automatic test_mispredict();
      apply_reset();
      set_alloc(4'hF);
      tick();
      set_alloc(4'hF);
      tick();
      for (int l = 0; l < 8; l++) set_wb(l, l, l == 5, (l == 5) ? 64'h8000_1000 : {$urandom, $urandom});
      tick();
      nvec++; if (commit_valid_o !== 4'b0) begin nerr++; $display("FAIL misp_wb got %b exp 0", commit_valid_o); end
      tick();
      nvec++; if (dut_reg() !== exp_reg()) begin nerr++; $display("FAIL misp_first got %h exp %h", dut_reg(), exp_reg()); end
      nvec++; if ({commit_valid_o, redirect_valid_o} !== {4'hF, 1'b0}) begin nerr++; $display("FAIL misp_first_cv got %b exp 11110", {commit_valid_o, redirect_valid_o}); end
      tick();
      nvec++; if (dut_reg() !== exp_reg()) begin nerr++; $display("FAIL misp_second got %h exp %h", dut_reg(), exp_reg()); end
      nvec++;
      if ({commit_valid_o, commit_rob_idx_o[0], commit_rob_idx_o[1], redirect_valid_o, redirect_pc_o, count_o}
          !== {4'b0011, 8'd4, 8'd5, 1'b1, 64'h8000_1000, 9'd0}) begin
         nerr++; $display("FAIL misp_redirect got cv=%b idx=%0d,%0d rv=%b pc=%h count=%0d exp cv=0011 idx=4,5 rv=1 pc=80001000 count=0",
                          commit_valid_o, commit_rob_idx_o[0], commit_rob_idx_o[1], redirect_valid_o, redirect_pc_o, count_o);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         nvec++; if ({commit_valid_o, redirect_valid_o, count_o} !== 14'b0) begin nerr++; $display("FAIL misp_after%0d got cv=%b rv=%b count=%0d exp all 0", c, commit_valid_o, redirect_valid_o, count_o); end
      end
   endtask

   task automatic test_wrap();
      for (int g = 0; g < 16; g++) begin
         set_alloc(g == 15 ? 4'b0011 : 4'hF);
         tick();
      end
      for (int c = 0; c < 80 && q.size() > 0; c++) begin
         complete_pending();
         tick();
         nvec++; if (dut_reg() !== exp_reg()) begin nerr++; $display("FAIL wrap_drain got %h exp %h", dut_reg(), exp_reg()); end
      end
      set_alloc(4'hF);
      #1;
      nvec++; if (dut_alloc() !== {1'b1, 8'd1, 8'd0, 8'd63, 8'd62}) begin nerr++; $display("FAIL wrap_alloc got %h exp 1_01_00_3f_3e", dut_alloc()); end
      tick();
      complete_pending();
      tick();
      tick();
      nvec++; if (dut_reg() !== exp_reg()) begin nerr++; $display("FAIL wrap_commit got %h exp %h", dut_reg(), exp_reg()); end
      nvec++;
      if ({commit_valid_o, commit_rob_idx_o[0], commit_rob_idx_o[1], commit_rob_idx_o[2], commit_rob_idx_o[3]}
          !== {4'hF, 8'd62, 8'd63, 8'd0, 8'd1}) begin
         nerr++; $display("FAIL wrap_order got cv=%b idx=%0d,%0d,%0d,%0d exp cv=1111 idx=62,63,0,1",
                          commit_valid_o, commit_rob_idx_o[0], commit_rob_idx_o[1], commit_rob_idx_o[2], commit_rob_idx_o[3]);
      end
   endtask

   task automatic test_flush();
      set_alloc(4'hF);
      tick();
      set_alloc(4'hF);
      tick();
      set_alloc(4'b0011);
      tick();
      nvec++; if (count_o !== 9'd10) begin nerr++; $display("FAIL flush_live got %0d exp 10", count_o); end
      set_wb(0, q[0].idx, 1'b0, 64'h0);
      set_wb(1, q[1].idx, 1'b1, 64'h1234);
      set_alloc(4'hF);
      flush_i = 1'b1;
      #1;
      nvec++; if (alloc_ready_o !== 1'b0) begin nerr++; $display("FAIL flush_ready got %b exp 0", alloc_ready_o); end
      tick();
      for (int c = 0; c < 2; c++) begin
         nvec++; if ({commit_valid_o, redirect_valid_o, count_o} !== 14'b0) begin nerr++; $display("FAIL flush_cleared%0d got cv=%b rv=%b count=%0d exp all 0", c, commit_valid_o, redirect_valid_o, count_o); end
         tick();
      end
      set_alloc(4'hF);
      #1;
      nvec++; if (dut_alloc() !== exp_alloc()) begin nerr++; $display("FAIL flush_realloc got %h exp %h", dut_alloc(), exp_alloc()); end
      clr_inputs();
   endtask

   task automatic test_reset_mid();
      logic any;
      set_alloc(4'hF);
      tick();
      complete_pending();
      tick();
      tick();
      nvec++; if (commit_valid_o !== 4'hF) begin nerr++; $display("FAIL rstmid_pre got %b exp 1111", commit_valid_o); end
      #2;
      rst_n = 1'b0;
      #1;
      any = |commit_valid_o | redirect_valid_o | (|redirect_pc_o) | (|count_o) | (|commit_has_dest_o);
      for (int k = 0; k < 4; k++)
         any = any | (|commit_rob_idx_o[k]) | (|commit_arch_o[k]) | (|commit_dest_phys_o[k]) | (|commit_old_phys_o[k]);
      nvec++; if (any !== 1'b0) begin nerr++; $display("FAIL rstmid_outputs got nonzero=%b exp 0", any); end
      nvec++; if (dut_alloc() !== {1'b1, 32'h0}) begin nerr++; $display("FAIL rstmid_alloc got %h exp 100000000", dut_alloc()); end
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      int cand[$];
      logic [255:0] used;
      int idx, r, p;
      for (int c = 0; c < 400; c++) begin
         cand.delete();
         used = '0;
         foreach (q[j]) if (!q[j].done) cand.push_back(q[j].idx);
         if ($urandom_range(0, 1) == 1) set_alloc(4'($urandom_range(0, 15)));
         for (int l = 0; l < 8; l++) begin
            if ($urandom_range(0, 2) == 0) continue;
            r = $urandom_range(0, 7);
            if (r < 5 && cand.size() > 0) begin
               p = $urandom_range(0, cand.size() - 1);
               idx = cand[p];
               cand.delete(p);
            end else if (r == 5) idx = $urandom_range(0, 63);
            else idx = $urandom_range(64, 255);
            if (!used[idx]) begin
               used[idx] = 1'b1;
               set_wb(l, idx, $urandom_range(0, 31) == 0, {$urandom, $urandom});
            end
         end
         flush_i = ($urandom_range(0, 39) == 0);
         #1;
         nvec++; if (dut_alloc() !== exp_alloc()) begin nerr++; $display("FAIL rand_alloc c%0d got %h exp %h", c, dut_alloc(), exp_alloc()); end
         tick();
         nvec++; if (dut_reg() !== exp_reg()) begin nerr++; $display("FAIL rand_outputs c%0d got %h exp %h", c, dut_reg(), exp_reg()); end
      end
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_out_of_order();
      test_full();
      test_mispredict();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
